// File: rtl/rf_wb_queue.sv
// ============================================================================
// Module   : rf_wb_queue
// Brief    : Two-producer write-back queue with round-robin arbitration,
//            in-order drain into a 2R1W register file, and read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    // producer A (ALU)
    input  logic                        A_VALID,
    output logic                        A_READY,
    input  logic [ADDR_W-1:0]           A_ADDR,
    input  logic [DATA_W-1:0]           A_DATA,
    // producer B (load/store unit)
    input  logic                        B_VALID,
    output logic                        B_READY,
    input  logic [ADDR_W-1:0]           B_ADDR,
    input  logic [DATA_W-1:0]           B_DATA,
    // register-file write port
    input  logic                        HOLD,
    output logic                        WE,
    output logic [ADDR_W-1:0]           RW,
    output logic [DATA_W-1:0]           DW,
    // register-file read ports
    input  logic [ADDR_W-1:0]           RA,
    input  logic [ADDR_W-1:0]           RB,
    input  logic [DATA_W-1:0]           DA_RF,
    input  logic [DATA_W-1:0]           DB_RF,
    output logic [DATA_W-1:0]           DA,
    output logic [DATA_W-1:0]           DB,
    output logic [$clog2(DEPTH):0]      COUNT
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] head_q;
    logic [c_ptr_w-1:0] tail_q;
    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;
    logic               last_b_q;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_empty;
    logic               w_full;
    logic               w_we;
    logic               w_can_enq;
    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_push_a;
    logic               w_push_b;
    logic               w_push;
    logic [ADDR_W-1:0]  w_push_addr;
    logic [DATA_W-1:0]  w_push_data;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == c_cnt_w'(DEPTH));
    // Reset suppresses the drain so no pending entry leaks into the register file.
    assign w_we      = !w_empty && !HOLD && !RST;
    assign w_can_enq = !w_full || w_we;

    // last_b_q=1 means B was granted most recently, so A wins a tie.
    assign w_grant_a = A_VALID && (!B_VALID || last_b_q);
    assign w_grant_b = B_VALID && (!A_VALID || !last_b_q);

    assign A_READY   = w_grant_a && w_can_enq && !RST;
    assign B_READY   = w_grant_b && w_can_enq && !RST;

    assign w_push_a    = A_VALID && A_READY;
    assign w_push_b    = B_VALID && B_READY;
    assign w_push      = w_push_a || w_push_b;
    assign w_push_addr = w_push_a ? A_ADDR : B_ADDR;
    assign w_push_data = w_push_a ? A_DATA : B_DATA;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_we) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_push && w_we) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and arbitration history
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            last_b_q <= 1'b1;
        end else begin
            if (w_we) begin
                head_q <= head_q + c_ptr_w'(1);
            end
            if (w_push) begin
                tail_q   <= tail_q + c_ptr_w'(1);
                last_b_q <= w_push_b;
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage; contents are qualified by count_q so need no reset
    // ------------------------------------------------------------------
    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (!RST && w_push && (tail_q == c_ptr_w'(e))) begin
                    addr_q[e] <= w_push_addr;
                    data_q[e] <= w_push_data;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write port and occupancy outputs
    // ------------------------------------------------------------------
    assign WE    = w_we;
    assign RW    = w_empty ? '0 : addr_q[head_q];
    assign DW    = w_empty ? '0 : data_q[head_q];
    assign COUNT = count_q;

    // ------------------------------------------------------------------
    // Read forwarding: scan oldest to youngest so the youngest match wins
    // ------------------------------------------------------------------
    always_comb begin
        DA = DA_RF;
        DB = DB_RF;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_cnt_w'(i) < count_q) begin
                if (addr_q[head_q + c_ptr_w'(i)] == RA) begin
                    DA = data_q[head_q + c_ptr_w'(i)];
                end
                if (addr_q[head_q + c_ptr_w'(i)] == RB) begin
                    DB = data_q[head_q + c_ptr_w'(i)];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
// ============================================================================
// Module   : tb_rf_wb_queue
// Brief    : Self-checking bench for rf_wb_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_VALID, B_VALID, HOLD;
    logic        A_READY, B_READY, WE;
    logic [4:0]  A_ADDR, B_ADDR, RA, RB, RW;
    logic [31:0] A_DATA, B_DATA, DA_RF, DB_RF, DA, DB, DW;
    logic [2:0]  COUNT;

    always #5 CLK = ~CLK;

    rf_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
        .HOLD(HOLD), .WE(WE), .RW(RW), .DW(DW),
        .RA(RA), .RB(RB), .DA_RF(DA_RF), .DB_RF(DB_RF), .DA(DA), .DB(DB),
        .COUNT(COUNT)
    );

    // Register file stand-in, written only by the DUT's write port
    logic [31:0] rf [32] = '{default: '0};
    always @(posedge CLK) if (WE === 1'b1) rf[RW] <= DW;
    assign DA_RF = rf[RA];
    assign DB_RF = rf[RB];

    // Reference model: pending writes as a FIFO queue plus expected RF contents
    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        mq [$];
    logic [31:0] mrf [32] = '{default: '0};
    logic        mlast_b = 1'b1;
    int          checks = 0;
    int          errors = 0;

    function automatic logic m_can_enq();
        return (mq.size() < DEPTH) || (mq.size() > 0 && !HOLD);
    endfunction

    function automatic logic m_ready_a();
        return !RST && A_VALID && (!B_VALID || mlast_b) && m_can_enq();
    endfunction

    function automatic logic m_ready_b();
        return !RST && B_VALID && (!A_VALID || !mlast_b) && m_can_enq();
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] addr);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == addr) return mq[i].d;
        end
        return mrf[addr];
    endfunction

    // Advance one clock, applying the model's view of this cycle's transfers
    task automatic tick();
        logic we, pa, pb;
        ent_t ne;
        we = (mq.size() > 0) && !HOLD && !RST;
        pa = m_ready_a();
        pb = m_ready_b();
        ne = pa ? '{a: A_ADDR, d: A_DATA} : '{a: B_ADDR, d: B_DATA};
        @(posedge CLK);
        if (RST) begin
            mq.delete();
            mlast_b = 1'b1;
        end else begin
            if (we) begin
                mrf[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (pa || pb) begin
                mq.push_back(ne);
                mlast_b = pb;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; A_VALID = 1'b1; B_VALID = 1'b1; RA = 5'd5; RB = 5'd6;
        #1;
        checks++; if (A_READY !== 1'b0) begin errors++; $display("FAIL rst_a_ready_in_rst got %b want 0", A_READY); end
        tick();
        RST = 1'b0;
        #1;
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", COUNT); end
        checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", WE); end
        checks++; if (RW !== 5'd0 || DW !== 32'd0) begin errors++; $display("FAIL rst_rw_dw got %0d/%h want 0/0", RW, DW); end
        checks++; if (A_READY !== 1'b1 || B_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got A=%b B=%b want A=1 B=0", A_READY, B_READY); end
        checks++; if (DA !== mrf[5] || DB !== mrf[6]) begin errors++; $display("FAIL rst_fwd got %h/%h want %h/%h", DA, DB, mrf[5], mrf[6]); end
        A_VALID = 1'b0; B_VALID = 1'b0;
    endtask

    task automatic test_single_write();
        A_VALID = 1'b1; A_ADDR = 5'd3; A_DATA = 32'hDEADBEEF; RA = 5'd3;
        #1;
        checks++; if (A_READY !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", A_READY); end
        checks++; if (DA !== 32'd0) begin errors++; $display("FAIL single_no_bypass got %h want 0", DA); end
        tick();
        A_VALID = 1'b0;
        #1;
        checks++; if (WE !== 1'b1 || RW !== 5'd3 || DW !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write got WE=%b RW=%0d DW=%h want 1/3/deadbeef", WE, RW, DW); end
        checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", COUNT); end
        checks++; if (DA !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_n1 got %h want deadbeef", DA); end
        tick();
        checks++; if (COUNT !== 3'd0 || WE !== 1'b0) begin errors++; $display("FAIL single_drained got COUNT=%0d WE=%b want 0/0", COUNT, WE); end
        checks++; if (DA !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_n2 got %h want deadbeef", DA); end
    endtask

    task automatic test_round_robin();
        RST = 1'b1; tick(); RST = 1'b0;
        A_VALID = 1'b1; B_VALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A_ADDR = 5'($urandom_range(1, 31)); A_DATA = $urandom;
            B_ADDR = 5'($urandom_range(1, 31)); B_DATA = $urandom;
            #1;
            checks++; if (A_READY !== (i % 2 == 0) || B_READY !== (i % 2 == 1)) begin errors++; $display("FAIL rr_grant[%0d] got A=%b B=%b want A=%b", i, A_READY, B_READY, (i % 2 == 0)); end
            checks++; if (COUNT > 3'd1) begin errors++; $display("FAIL rr_count[%0d] got %0d want <=1", i, COUNT); end
            if (mq.size() > 0) begin
                checks++; if (WE !== 1'b1 || RW !== mq[0].a || DW !== mq[0].d) begin errors++; $display("FAIL rr_write[%0d] got %b/%0d/%h want 1/%0d/%h", i, WE, RW, DW, mq[0].a, mq[0].d); end
            end
            tick();
        end
        A_VALID = 1'b0; B_VALID = 1'b0;
        tick();
    endtask

    task automatic test_fill_hold();
        HOLD = 1'b1; A_VALID = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            A_ADDR = 5'(k); A_DATA = 32'h100 + 32'(k);
            #1;
            checks++; if (A_READY !== 1'b1 || WE !== 1'b0) begin errors++; $display("FAIL fill_accept[%0d] got READY=%b WE=%b want 1/0", k, A_READY, WE); end
            tick();
        end
        A_ADDR = 5'd9; RA = 5'd2;
        #1;
        checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", COUNT); end
        checks++; if (A_READY !== 1'b0 || WE !== 1'b0) begin errors++; $display("FAIL fill_full got READY=%b WE=%b want 0/0", A_READY, WE); end
        checks++; if (DA !== 32'h102) begin errors++; $display("FAIL fill_fwd got %h want 102", DA); end
        tick();
        HOLD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            A_ADDR = 5'(10 + k); A_DATA = 32'h200 + 32'(k);
            #1;
            checks++; if (WE !== 1'b1 || RW !== 5'(k + 1) || DW !== 32'h101 + 32'(k)) begin errors++; $display("FAIL fill_drain[%0d] got %b/%0d/%h want 1/%0d/%h", k, WE, RW, DW, k + 1, 32'h101 + 32'(k)); end
            checks++; if (A_READY !== 1'b1 || COUNT !== 3'd4) begin errors++; $display("FAIL fill_stream[%0d] got READY=%b COUNT=%0d want 1/4", k, A_READY, COUNT); end
            tick();
        end
        A_VALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (RW !== 5'(10 + k) || DW !== 32'h200 + 32'(k)) begin errors++; $display("FAIL fill_tail[%0d] got %0d/%h want %0d/%h", k, RW, DW, 10 + k, 32'h200 + 32'(k)); end
            tick();
        end
    endtask

    task automatic test_youngest_wins();
        HOLD = 1'b1; A_VALID = 1'b1; A_ADDR = 5'd7; A_DATA = 32'h11;
        #1; tick();
        A_DATA = 32'h22;
        #1; tick();
        A_VALID = 1'b0; RA = 5'd7; RB = 5'd8;
        #1;
        checks++; if (DA !== 32'h22) begin errors++; $display("FAIL young_da got %h want 22", DA); end
        checks++; if (DB !== mrf[8]) begin errors++; $display("FAIL young_db got %h want %h", DB, mrf[8]); end
        HOLD = 1'b0;
        #1;
        checks++; if (WE !== 1'b1 || RW !== 5'd7 || DW !== 32'h11) begin errors++; $display("FAIL young_first got %b/%0d/%h want 1/7/11", WE, RW, DW); end
        tick();
        checks++; if (DW !== 32'h22 || DA !== 32'h22) begin errors++; $display("FAIL young_second got DW=%h DA=%h want 22/22", DW, DA); end
        tick();
        checks++; if (rf[7] !== 32'h22 || COUNT !== 3'd0) begin errors++; $display("FAIL young_rf got %h count %0d want 22/0", rf[7], COUNT); end
    endtask

    task automatic test_reset_mid();
        HOLD = 1'b1; A_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            A_ADDR = 5'(20 + k); A_DATA = 32'h300 + 32'(k);
            #1; tick();
        end
        RST = 1'b1; HOLD = 1'b0;
        #1;
        checks++; if (WE !== 1'b0 || A_READY !== 1'b0) begin errors++; $display("FAIL rstmid_in_rst got WE=%b READY=%b want 0/0", WE, A_READY); end
        tick();
        RST = 1'b0; A_VALID = 1'b0; RA = 5'd21;
        #1;
        checks++; if (COUNT !== 3'd0 || DA !== mrf[21]) begin errors++; $display("FAIL rstmid_after got COUNT=%0d DA=%h want 0/%h", COUNT, DA, mrf[21]); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rstmid_we[%0d] got %b want 0", k, WE); end
            tick();
        end
        checks++; if (rf[20] !== mrf[20] || rf[22] !== mrf[22]) begin errors++; $display("FAIL rstmid_rf got %h/%h want %h/%h", rf[20], rf[22], mrf[20], mrf[22]); end
    endtask

    task automatic test_full_push_pop();
        HOLD = 1'b1; A_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            A_ADDR = 5'(12 + k); A_DATA = 32'h400 + 32'(k);
            #1; tick();
        end
        A_VALID = 1'b0; HOLD = 1'b0; B_VALID = 1'b1; B_ADDR = 5'd16; B_DATA = 32'h4BB;
        #1;
        checks++; if (B_READY !== 1'b1 || COUNT !== 3'd4 || RW !== 5'd12) begin errors++; $display("FAIL full_pp got READY=%b COUNT=%0d RW=%0d want 1/4/12", B_READY, COUNT, RW); end
        tick();
        B_VALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (COUNT !== 3'(4 - k) || RW !== 5'(13 + k)) begin errors++; $display("FAIL full_order[%0d] got COUNT=%0d RW=%0d want %0d/%0d", k, COUNT, RW, 4 - k, 13 + k); end
            tick();
        end
        checks++; if (rf[16] !== 32'h4BB) begin errors++; $display("FAIL full_wrap_rf got %h want 4bb", rf[16]); end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        for (int n = 0; n < 500; n++) begin
            RST     = ($urandom_range(0, 79) == 0);
            HOLD    = ($urandom_range(0, 3) == 0);
            A_VALID = $urandom_range(0, 1) == 1;
            B_VALID = $urandom_range(0, 1) == 1;
            A_ADDR  = 5'($urandom_range(0, 7)); A_DATA = $urandom;
            B_ADDR  = 5'($urandom_range(0, 7)); B_DATA = $urandom;
            RA      = 5'($urandom_range(0, 7)); RB = 5'($urandom_range(0, 7));
            #1;
            checks++; if (COUNT !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, COUNT, mq.size()); end
            checks++; if (WE !== ((mq.size() > 0) && !HOLD && !RST)) begin errors++; $display("FAIL rnd_we[%0d] got %b", n, WE); end
            if (mq.size() > 0) begin
                checks++; if (RW !== mq[0].a || DW !== mq[0].d) begin errors++; $display("FAIL rnd_head[%0d] got %0d/%h want %0d/%h", n, RW, DW, mq[0].a, mq[0].d); end
            end
            if (A_VALID) begin
                checks++; if (A_READY !== m_ready_a()) begin errors++; $display("FAIL rnd_a_ready[%0d] got %b want %b", n, A_READY, m_ready_a()); end
            end
            if (B_VALID) begin
                checks++; if (B_READY !== m_ready_b()) begin errors++; $display("FAIL rnd_b_ready[%0d] got %b want %b", n, B_READY, m_ready_b()); end
            end
            ea = m_fwd(RA);
            eb = m_fwd(RB);
            checks++; if (DA !== ea || DB !== eb) begin errors++; $display("FAIL rnd_fwd[%0d] got %h/%h want %h/%h", n, DA, DB, ea, eb); end
            tick();
        end
        RST = 1'b0; HOLD = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
        for (int k = 0; k <= DEPTH; k++) tick();
        for (int r = 0; r < 32; r++) begin
            checks++; if (rf[r] !== mrf[r]) begin errors++; $display("FAIL rnd_rf[%0d] got %h want %h", r, rf[r], mrf[r]); end
        end
    endtask

    initial begin
        RST = 1'b1; HOLD = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
        A_ADDR = '0; A_DATA = '0; B_ADDR = '0; B_DATA = '0; RA = '0; RB = '0;
        tick(); tick();
        test_reset();
        test_single_write();
        test_round_robin();
        test_fill_hold();
        test_youngest_wins();
        test_reset_mid();
        test_full_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
